// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-requester round-robin arbiter onto a single-port memory
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_data_in,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [DATA_W-1:0]     mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [64:0] c_DEPTH = 65'(DEPTH);

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                id_q, id_d;
    logic                write_q, write_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [DATA_W-1:0]   mdin_q, mdin_d;

    logic                w_gnt_id;
    logic [1:0]          w_grant;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_oor;

    // Pointer only matters when both requesters compete.
    assign w_gnt_id    = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    assign w_sel_addr  = w_gnt_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign w_sel_wdata = w_gnt_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign w_oor       = (65'(w_sel_addr) >= c_DEPTH);

    always_comb begin
        w_grant = 2'b00;
        if (state_q == S_IDLE && req_valid != 2'b00) begin
            w_grant = w_gnt_id ? 2'b10 : 2'b01;
        end
    end

    // Reset gates the grant so nothing is accepted while rst is held.
    assign req_ready = w_grant & {2{~rst}};

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        id_d             = id_q;
        write_d          = write_q;
        err_d            = err_q;
        rdata_d          = rdata_q;
        maddr_d          = maddr_q;
        mdin_d           = mdin_q;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        rsp_valid        = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    id_d    = w_gnt_id;
                    write_d = req_write[w_gnt_id];
                    ptr_d   = ~w_gnt_id;
                    rdata_d = '0;
                    err_d   = w_oor;
                    if (w_oor) begin
                        state_d = S_RESP;
                    end else begin
                        maddr_d = w_sel_addr;
                        mdin_d  = w_sel_wdata;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                mem_write_enable = write_q;
                mem_read_enable  = ~write_q;
                state_d          = write_q ? S_RESP : S_CAPTURE;
            end
            S_CAPTURE: begin
                rdata_d = mem_data_out;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid[id_q] = 1'b1;
                if (rsp_ready[id_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            maddr_q <= '0;
            mdin_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            write_q <= write_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            maddr_q <= maddr_d;
            mdin_q  <= mdin_d;
        end
    end

    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign mem_address = maddr_q;
    assign mem_data_in = mdin_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_write;
    logic [63:0]  req_addr;
    logic [127:0] req_wdata;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [63:0]  rsp_rdata;
    logic         rsp_err;
    logic [31:0]  mem_address;
    logic [63:0]  mem_data_in;
    logic         mem_write_enable;
    logic         mem_read_enable;
    logic [63:0]  mem_data_out;

    int n_checks;
    int n_errors;
    int re_cnt;
    int we_cnt;
    logic both_seen;

    logic [63:0] mem [0:16383];

    mem_arbiter #(.ADDR_W(32), .DATA_W(64), .DEPTH(16384)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_data_out     (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data appears one clock after the read-enable edge.
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[13:0]] <= mem_data_in;
        if (mem_read_enable)  mem_data_out <= mem[mem_address[13:0]];
        if (mem_read_enable)  re_cnt <= re_cnt + 1;
        if (mem_write_enable) we_cnt <= we_cnt + 1;
        if (mem_read_enable && mem_write_enable) both_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction from requester r, entered and left at a negedge.
    task automatic txn(input int r, input logic wr, input logic [31:0] addr,
                       input logic [63:0] wd, input int exp_lat,
                       input logic [63:0] exp_rd, input logic exp_err);
        logic [1:0]  oh;
        logic [31:0] a0;
        int          k, re0, we0;
        oh  = (r == 1) ? 2'b10 : 2'b01;
        re0 = re_cnt;
        we0 = we_cnt;
        a0  = mem_address;
        req_valid = oh;
        req_write = {wr, wr};
        req_addr  = {addr, addr};
        req_wdata = {wd, wd};
        rsp_ready = ~oh;
        #1;
        k = 0;
        while (req_ready != oh && k < 20) begin
            @(negedge clk); #1; k++;
        end
        check("grant", 64'(req_ready), 64'(oh));
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        k = 1;
        while (rsp_valid == 2'b00 && k < 10) begin
            @(negedge clk); k++;
        end
        check("latency",   64'(k), 64'(exp_lat));
        check("rsp_valid", 64'(rsp_valid), 64'(oh));
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err",   64'(rsp_err), 64'(exp_err));
        check("re_count",  64'(re_cnt - re0), 64'((!wr && !exp_err) ? 1 : 0));
        check("we_count",  64'(we_cnt - we0), 64'((wr && !exp_err) ? 1 : 0));
        if (exp_err) check("addr_hold", 64'(mem_address), 64'(a0));
        rsp_ready = oh;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 2'b00;
        check("rsp_done", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        logic [1:0]  exp_g;
        logic [63:0] exp_d, hold_d;
        int          k, bad;
        n_checks  = 0;
        n_errors  = 0;
        re_cnt    = 0;
        we_cnt    = 0;
        both_seen = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 64'd0;
        mem[5] = 64'hDEADBEEF_CAFEF00D;
        mem[9] = 64'h01234567_89ABCDEF;
        mem_data_out = 64'd0;
        rst       = 1'b1;
        req_valid = 2'b11;
        req_write = 2'b00;
        req_addr  = {32'd9, 32'd5};
        req_wdata = '0;
        rsp_ready = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_strobes",   64'({mem_read_enable, mem_write_enable}), 64'd0);
        rst = 1'b0;

        // Contention from reset: both requesters stay valid across four transactions.
        for (int t = 0; t < 4; t++) begin
            exp_g = (t % 2 == 1) ? 2'b10 : 2'b01;
            exp_d = (t % 2 == 1) ? 64'h01234567_89ABCDEF : 64'hDEADBEEF_CAFEF00D;
            #1;
            k = 0;
            while (req_ready == 2'b00 && k < 20) begin
                @(negedge clk); #1; k++;
            end
            check("rr_grant", 64'(req_ready), 64'(exp_g));
            @(posedge clk);
            @(negedge clk);
            k = 1;
            while (rsp_valid == 2'b00 && k < 10) begin
                @(negedge clk); k++;
            end
            check("rr_latency", 64'(k), 64'd3);
            check("rr_valid",   64'(rsp_valid), 64'(exp_g));
            check("rr_rdata",   rsp_rdata, exp_d);
            if (t == 0) begin
                hold_d = rsp_rdata;
                bad = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (rsp_valid !== exp_g || rsp_rdata !== hold_d || req_ready !== 2'b00) bad++;
                end
                check("rr_stall_stable", 64'(bad), 64'd0);
            end
            rsp_ready = exp_g;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
        @(negedge clk);

        txn(0, 1'b0, 32'd5, 64'd0, 3, 64'hDEADBEEF_CAFEF00D, 1'b0);
        txn(1, 1'b1, 32'd7, 64'h1234, 2, 64'd0, 1'b0);
        txn(1, 1'b0, 32'd7, 64'd0, 3, 64'h1234, 1'b0);
        txn(0, 1'b0, 32'd16384, 64'd0, 1, 64'd0, 1'b1);
        txn(1, 1'b1, 32'hFFFF_FFFF, 64'h55, 1, 64'd0, 1'b1);
        txn(0, 1'b1, 32'd16383, 64'hA5A5_0000_0000_5A5A, 2, 64'd0, 1'b0);
        txn(0, 1'b0, 32'd16383, 64'd0, 3, 64'hA5A5_0000_0000_5A5A, 1'b0);
        check("no_dual_strobe", 64'(both_seen), 64'd0);

        // Reset while the read sits in CAPTURE.
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = {32'd9, 32'd5};
        #1;
        check("mid_grant", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_req_ready", 64'(req_ready), 64'd0);
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rdata",     rsp_rdata, 64'd0);
        check("mid_err",       64'(rsp_err), 64'd0);
        check("mid_addr",      64'(mem_address), 64'd0);
        check("mid_wdata",     mem_data_in, 64'd0);
        check("mid_strobes",   64'({mem_read_enable, mem_write_enable}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00) bad++;
        end
        check("mid_no_resp", 64'(bad), 64'd0);
        req_valid = 2'b11;
        #1;
        check("post_rst_ptr", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        k = 1;
        while (rsp_valid == 2'b00 && k < 10) begin
            @(negedge clk); k++;
        end
        check("post_rst_latency", 64'(k), 64'd3);
        check("post_rst_rdata", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
        rsp_ready = 2'b01;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of requests and memory port.
REQ-002 Parameter DATA_W, default 64, data width of requests, responses and memory port.
REQ-003 Parameter DEPTH, default 16384, number of memory words; any address >= DEPTH is out of range.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 req_valid  input  2  request valid; bit i belongs to requester i.
REQ-007 req_ready  output  2  request accept, at most one bit set.
REQ-008 req_write  input  2  1 = write, 0 = read, per requester.
REQ-009 req_addr  input  2*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  2*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W].
REQ-011 rsp_valid  output  2  response valid to requester i, at most one bit set.
REQ-012 rsp_ready  input  2  response accept from requester i.
REQ-013 rsp_rdata  output  DATA_W  read data of current response.
REQ-014 rsp_err  output  1  1 = out-of-range request, no memory access made.
REQ-015 mem_address  output  ADDR_W  memory word address.
REQ-016 mem_data_in  output  DATA_W  memory write data.
REQ-017 mem_write_enable, mem_read_enable  output  1 each  memory strobes.
REQ-018 mem_data_out  input  DATA_W  memory read data, valid one clock after the read-enable edge.

Function
REQ-019 FSM states IDLE, ISSUE, CAPTURE, RESP; one transaction in flight maximum.
REQ-020 IDLE: req_ready = one-hot grant when any req_valid set; req_ready = 0 in all other states.
REQ-021 Arbitration round-robin: single valid -> grant it; both valid -> grant requester named by pointer; pointer = index of the other requester after every accepted request.
REQ-022 Accept (req_valid[i] & req_ready[i]): latch id, write, addr, wdata; in-range -> ISSUE; out-of-range -> RESP with rsp_err = 1, rsp_rdata = 0, no memory strobe.
REQ-023 ISSUE (exactly one cycle): drive mem_address and mem_data_in from latched values, assert mem_read_enable (read) or mem_write_enable (write); read -> CAPTURE, write -> RESP.
REQ-024 Both memory strobes 0 outside ISSUE; never both 1; mem_address and mem_data_in hold last values outside ISSUE.
REQ-025 CAPTURE: register mem_data_out into rsp_rdata at the cycle's end edge -> RESP.
REQ-026 RESP: rsp_valid[id] = 1; rsp_rdata and rsp_err stable until rsp_ready[id]; on that handshake -> IDLE.
REQ-027 Write responses: rsp_rdata = 0, rsp_err = 0.
REQ-028 rsp_ready[other than id] ignored; req_valid changes while not granted have no effect.
REQ-029 Latency from accept edge N: read rsp_valid at N+3, write at N+2, error at N+1; next accept no earlier than the cycle after the response handshake.

Reset
REQ-030 rst assertion immediately (asynchronously): state IDLE, pointer 0, in-flight transaction discarded with no response, all outputs 0.
REQ-031 req_ready held 0 while rst = 1; first accept possible at the first rising edge after rst deasserts.

Verification
REQ-032 Read: memory word 5 = 0xDEADBEEF_CAFEF00D, requester 0 reads addr 5 -> mem_read_enable one cycle, rsp_valid = 2'b01 at N+3, rsp_rdata = 0xDEADBEEF_CAFEF00D, rsp_err = 0.
REQ-033 Write then read: requester 1 writes 0x1234 to addr 7, then reads addr 7 -> write rsp at N+2 with rdata 0; read returns 0x1234 on rsp_valid = 2'b10.
REQ-034 Contention: both valid for 4 transactions from reset -> grants 0,1,0,1; rsp_ready held 0 for 3 cycles -> rsp_valid/rsp_rdata stable, no new accept.
REQ-035 Out of range: read addr 16384 -> rsp_err = 1 at N+1, rsp_rdata = 0, no memory strobe.
REQ-036 Reset mid-read: rst asserted during CAPTURE -> all outputs 0 immediately; no response after deassert; next request serviced normally from pointer 0.
